display_scan_driver: RTL and testbench
======================================

# display_scan_driver

Time-multiplexed driver for the scoreboard's multi-digit 7-segment displays, the parametrised successor to the single-digit BCD decoder. It holds a double-buffered copy of up to 8 BCD digits and scans them onto one shared active-low segment bus and active-low digit selects. It adds leading-zero blanking, per-digit blink, optional hex decode and a frame marker. One instance drives each score/clock field of the scoreboard.

## Interface

- DIGITS, 4: number of digits scanned, 1..8.
- SCAN_DIV, 50000: clock cycles each digit is driven, ≥2.
- BLINK_DIV, 64: scan frames per blink half-period, ≥1.
- HEX_MODE, 0: 0 = codes 10–15 blank; 1 = codes 10–15 show A b C d E F.

- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- load  in  1  capture digits_in into the shadow register.
- digits_in  in  4*DIGITS  packed codes; digit 0 (rightmost) = [3:0].
- blink_mask  in  DIGITS  bit i = digit i blinks.
- lz_blank  in  1  leading-zero blanking enable.
- enable  in  1  0 = display dark; scan keeps running.
- seg_n  out  7  active-low segments, bit6..0 = g,f,e,d,c,b,a.
- an_n  out  DIGITS  active-low digit select; at most one bit low.
- frame_tick  out  1  one-cycle pulse marking start of each scan frame.

## Operation

- State: prescaler cnt (0..SCAN_DIV-1), digit index idx (0..DIGITS-1), frame counter fcnt (0..BLINK_DIV-1), blink phase ph, shadow register, output registers.
- Each edge: cnt increments; at SCAN_DIV-1, cnt→0 and idx→idx+1, with DIGITS-1 wrapping to 0.
- Frame wrap = (idx==DIGITS-1 && cnt==SCAN_DIV-1). On frame wrap fcnt increments; when fcnt==BLINK_DIV-1 it goes to 0 and ph toggles.
- load=1 at an edge writes digits_in into the shadow register. Live inputs never reach the decoder directly.
- Decode is fixed to the codebase pattern: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- HEX_MODE=1: A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110. HEX_MODE=0: codes 10–15 = 1111111.
- Blank (seg_n=1111111, anode still driven) when any of:
  - lz_blank=1, idx≠0, and shadow digits idx..DIGITS-1 are all zero (digit 0 is never LZ-blanked);
  - ph=1 and blink_mask[idx]=1.
- enable=0: an_n all ones and seg_n=1111111. Counters, blink phase and load are unaffected.
- blink_mask, lz_blank and enable are sampled live, not shadowed.

## Timing

- Reset values: cnt=0, idx=0, fcnt=0, ph=0, shadow=0, seg_n=1111111, an_n=all ones, frame_tick=0.
- Outputs are registered. The edge that ends cycle k loads an_n/seg_n from idx, shadow and controls as they were during cycle k, so there is one cycle of latency.
- Each digit is driven for exactly SCAN_DIV consecutive cycles. A full frame is DIGITS*SCAN_DIV cycles.
- frame_tick is registered from (idx==0 && cnt==0). It is high exactly in the first cycle an_n selects digit 0 of each frame, including the first frame after reset.
- Load at edge k: outputs from edge k+1 onward use the new data. A load coincident with an idx advance is applied the same way; both take effect.
- Blink: ph changes on frame-wrap edges, so it first affects outputs at the start of the next frame. Blank and lit intervals are exactly BLINK_DIV frames each.
- rst asserted mid-scan: all state and outputs go to reset values immediately, without waiting for clk, and the shadow is cleared. After rst deasserts, the first edge drives digit 0 (an_n bit0 low, seg_n=1000000) and pulses frame_tick.

## Test plan

Parameters for all scenarios: DIGITS=4, SCAN_DIV=4, BLINK_DIV=2.

1. Reset, then load digits_in=0x1234 with lz_blank=0 -> seg_n=1111111 / an_n=1111 during reset; once the load takes effect, an_n=1110 / seg_n=0011001 ("4") for 4 cycles, then 1101/0110000, 1011/0100100, 0111/1111001, then repeat. frame_tick pulses every 16 cycles, aligned with an_n=1110.
2. lz_blank=1, load 0x0050 -> digits 3 and 2 = 1111111, digit 1 = 0010010, digit 0 = 1000000. Then load 0x0000 -> only digit 0 lit (1000000). Then load 0x1000 -> nothing blanked.
3. Load 0x00A0 with lz_blank=0 -> digit 1 = 1111111 when HEX_MODE=0; 0001000 when HEX_MODE=1.
4. blink_mask=0001, load 0x8888 -> digit 0 shows 0000000 in frames 0–1, 1111111 in frames 2–3, lit again in frame 4. Digits 1–3 are never blanked. an_n still selects digit 0 while it is blank.
5. Assert rst asynchronously (between edges) while an_n=1011 -> seg_n=1111111 and an_n=1111 before the next edge. After release: an_n=1110, seg_n=1000000, frame_tick=1 on the first edge.
6. enable=0 for 2 frames -> an_n=1111 and seg_n=1111111 throughout, while frame_tick keeps its 16-cycle period. With enable=1 restored mid-frame, the digit currently indexed appears on the next edge.

Source files
------------

// File: rtl/display_scan_driver.sv
// Time-multiplexed 7-segment scan driver: double-buffered BCD/hex digits scanned onto a
// shared active-low segment bus with leading-zero blanking, per-digit blink and a frame marker.

module display_scan_lane #(
  parameter int HEX_MODE = 0
) (
  input  logic [3:0] code,
  output logic [6:0] seg,
  output logic       zero
);
  always_comb begin
    seg = 7'b1111111;
    case (code)
      4'd0:  seg = 7'b1000000;
      4'd1:  seg = 7'b1111001;
      4'd2:  seg = 7'b0100100;
      4'd3:  seg = 7'b0110000;
      4'd4:  seg = 7'b0011001;
      4'd5:  seg = 7'b0010010;
      4'd6:  seg = 7'b0000010;
      4'd7:  seg = 7'b1111000;
      4'd8:  seg = 7'b0000000;
      4'd9:  seg = 7'b0010000;
      4'd10: if (HEX_MODE != 0) seg = 7'b0001000;
      4'd11: if (HEX_MODE != 0) seg = 7'b0000011;
      4'd12: if (HEX_MODE != 0) seg = 7'b1000110;
      4'd13: if (HEX_MODE != 0) seg = 7'b0100001;
      4'd14: if (HEX_MODE != 0) seg = 7'b0000110;
      4'd15: if (HEX_MODE != 0) seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

  assign zero = (code == 4'd0);
endmodule

module display_scan_driver #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 64,
  parameter int HEX_MODE  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  lz_blank,
  input  logic                  enable,
  output logic [6:0]            seg_n,
  output logic [DIGITS-1:0]     an_n,
  output logic                  frame_tick
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);
  localparam logic [FW-1:0] FC_MAX  = FW'(BLINK_DIV - 1);

  logic [CW-1:0] cnt, cnt_nx;
  logic [IW-1:0] idx, idx_nx;
  logic [FW-1:0] fcnt, fcnt_nx;
  logic          ph, ph_nx;
  logic [DIGITS-1:0][3:0] shadow;

  logic [DIGITS-1:0][6:0] lane_seg;
  logic [DIGITS-1:0]      lane_zero;
  logic [DIGITS-1:0]      lz_run;
  logic                   lz_acc;
  logic                   blank;
  logic [6:0]             seg_d;
  logic [DIGITS-1:0]      an_d;

  // One decoder per digit; the scan mux only selects a finished pattern.
  for (genvar i = 0; i < DIGITS; i++) begin : g_lane
    display_scan_lane #(.HEX_MODE(HEX_MODE)) u_lane (
      .code (shadow[i]),
      .seg  (lane_seg[i]),
      .zero (lane_zero[i])
    );
  end

  // lz_run[i]: digit i and every digit to its left are zero.
  always_comb begin
    lz_run = '0;
    lz_acc = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lz_acc    = lz_acc & lane_zero[i];
      lz_run[i] = lz_acc;
    end
  end

  always_comb begin
    cnt_nx  = cnt + 1'b1;
    idx_nx  = idx;
    fcnt_nx = fcnt;
    ph_nx   = ph;
    if (cnt == CNT_MAX) begin
      cnt_nx = '0;
      idx_nx = (idx == IDX_MAX) ? '0 : idx + 1'b1;
      if (idx == IDX_MAX) begin
        if (fcnt == FC_MAX) begin
          fcnt_nx = '0;
          ph_nx   = ~ph;
        end else begin
          fcnt_nx = fcnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    blank = (lz_blank && (idx != '0) && lz_run[idx]) || (ph && blink_mask[idx]);
    an_d  = '1;
    seg_d = 7'b1111111;
    if (enable) begin
      an_d[idx] = 1'b0;
      if (!blank) seg_d = lane_seg[idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      fcnt       <= '0;
      ph         <= 1'b0;
      shadow     <= '0;
      seg_n      <= 7'b1111111;
      an_n       <= '1;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= cnt_nx;
      idx        <= idx_nx;
      fcnt       <= fcnt_nx;
      ph         <= ph_nx;
      seg_n      <= seg_d;
      an_n       <= an_d;
      frame_tick <= (idx == '0) && (cnt == '0);
      if (load) shadow <= digits_in;
    end
  end
endmodule

// File: tb/tb_display_scan_driver.sv
// Randomized bench for display_scan_driver; a time-indexed reference model predicts every cycle.

module tb_display_scan_driver;
  localparam int D  = 4;
  localparam int SD = 4;
  localparam int BD = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  blink_mask;
  logic        lz_blank;
  logic        enable;
  logic [6:0]  seg_n, seg_n_h;
  logic [3:0]  an_n, an_n_h;
  logic        frame_tick, frame_tick_h;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  display_scan_driver #(.DIGITS(D), .SCAN_DIV(SD), .BLINK_DIV(BD), .HEX_MODE(0)) dut (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .blink_mask(blink_mask),
    .lz_blank(lz_blank), .enable(enable), .seg_n(seg_n), .an_n(an_n), .frame_tick(frame_tick)
  );

  display_scan_driver #(.DIGITS(D), .SCAN_DIV(SD), .BLINK_DIV(BD), .HEX_MODE(1)) dut_hex (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .blink_mask(blink_mask),
    .lz_blank(lz_blank), .enable(enable), .seg_n(seg_n_h), .an_n(an_n_h),
    .frame_tick(frame_tick_h)
  );

  function automatic logic [6:0] dec(input logic [3:0] c, input bit hex);
    case (c)
      4'd0: return 7'b1000000;  4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;  4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;  4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;  4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;  4'd9: return 7'b0010000;
      4'd10: return hex ? 7'b0001000 : 7'b1111111;
      4'd11: return hex ? 7'b0000011 : 7'b1111111;
      4'd12: return hex ? 7'b1000110 : 7'b1111111;
      4'd13: return hex ? 7'b0100001 : 7'b1111111;
      4'd14: return hex ? 7'b0000110 : 7'b1111111;
      default: return hex ? 7'b0001110 : 7'b1111111;
    endcase
  endfunction

  // Reference model: position in the scan follows directly from cycles since reset.
  int         t;
  logic [15:0] sh;
  logic [6:0] e_seg, e_seg_h;
  logic [3:0] e_an;
  logic       e_ft;

  always @(posedge clk or posedge rst) begin : model
    int i, fr;
    logic bl;
    logic [3:0] code, onehot;
    if (rst) begin
      t = 0; sh = '0;
      e_seg = 7'h7f; e_seg_h = 7'h7f; e_an = 4'hf; e_ft = 1'b0;
    end else begin
      i      = (t / SD) % D;
      fr     = t / (D * SD);
      code   = sh[i*4 +: 4];
      bl     = (lz_blank && i != 0 && (sh >> (4 * i)) == 16'd0) ||
               (((fr / BD) % 2 == 1) && blink_mask[i]);
      onehot = 4'b0001 << i;
      e_ft   = (t % (D * SD)) == 0;
      e_an   = enable ? ~onehot : 4'hf;
      e_seg  = (!enable || bl) ? 7'h7f : dec(code, 1'b0);
      e_seg_h = (!enable || bl) ? 7'h7f : dec(code, 1'b1);
      if (load) sh = digits_in;
      t++;
    end
  end

  wire  [18:0] got  = {seg_n, seg_n_h, an_n, frame_tick};
  wire  [18:0] want = {e_seg, e_seg_h, e_an, e_ft};
  wire         hex_agree = (an_n_h === an_n) && (frame_tick_h === frame_tick);

  task automatic do_load(input logic [15:0] v);
    digits_in = v; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_an(input logic [3:0] v, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (an_n === v) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (got !== {7'h7f, 7'h7f, 4'hf, 1'b0}) begin
      bad++; $display("FAIL reset_idle got=%b want=%b", got, {7'h7f, 7'h7f, 4'hf, 1'b0});
    end
    repeat (3) @(negedge clk);
    total++;
    if (got !== {7'h7f, 7'h7f, 4'hf, 1'b0}) begin
      bad++; $display("FAIL reset_held got=%b want=%b", got, {7'h7f, 7'h7f, 4'hf, 1'b0});
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (got !== {7'b1000000, 7'b1000000, 4'b1110, 1'b1}) begin
      bad++; $display("FAIL reset_first_edge got=%b want=%b", got,
                      {7'b1000000, 7'b1000000, 4'b1110, 1'b1});
    end
  endtask

  task automatic test_scan();
    bit ok;
    lz_blank = 1'b0;
    do_load(16'h1234);
    wait_an(4'b1110, ok);
    total++;
    if (!ok || seg_n !== 7'b0011001) begin
      bad++; $display("FAIL scan_digit0 ok=%0d got seg=%b want seg=0011001", ok, seg_n);
    end
    repeat (40) begin
      @(negedge clk);
      total++;
      if (got !== want || !hex_agree) begin
        bad++; $display("FAIL scan t=%0d got=%b want=%b", t, got, want);
      end
    end
  endtask

  task automatic test_lz();
    bit ok;
    logic [15:0] pats [3] = '{16'h0050, 16'h0000, 16'h1000};
    lz_blank = 1'b1;
    foreach (pats[p]) begin
      do_load(pats[p]);
      repeat (20) begin
        @(negedge clk);
        total++;
        if (got !== want || !hex_agree) begin
          bad++; $display("FAIL lz pat=%h t=%0d got=%b want=%b", pats[p], t, got, want);
        end
      end
    end
    do_load(16'h0000);
    wait_an(4'b1101, ok);
    total++;
    if (!ok || seg_n !== 7'h7f) begin
      bad++; $display("FAIL lz_zero_digit1 ok=%0d got seg=%b want seg=1111111", ok, seg_n);
    end
    wait_an(4'b1110, ok);
    total++;
    if (!ok || seg_n !== 7'b1000000) begin
      bad++; $display("FAIL lz_zero_digit0 ok=%0d got seg=%b want seg=1000000", ok, seg_n);
    end
    lz_blank = 1'b0;
  endtask

  task automatic test_hex();
    bit ok;
    do_load(16'h00A0);
    wait_an(4'b1101, ok);
    total++;
    if (!ok || seg_n !== 7'h7f || seg_n_h !== 7'b0001000) begin
      bad++; $display("FAIL hex_digit1 ok=%0d got seg=%b/%b want seg=1111111/0001000",
                      ok, seg_n, seg_n_h);
    end
    repeat (16) begin
      @(negedge clk);
      total++;
      if (got !== want || !hex_agree) begin
        bad++; $display("FAIL hex t=%0d got=%b want=%b", t, got, want);
      end
    end
  endtask

  task automatic test_blink();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    blink_mask = 4'b0001;
    do_load(16'h8888);
    repeat (86) begin
      @(negedge clk);
      total++;
      if (got !== want || !hex_agree) begin
        bad++; $display("FAIL blink t=%0d got=%b want=%b", t, got, want);
      end
    end
    blink_mask = 4'b0000;
  endtask

  task automatic test_async_reset();
    bit ok;
    wait_an(4'b1011, ok);
    #2 rst = 1'b1;
    #1;
    total++;
    if (!ok || got !== {7'h7f, 7'h7f, 4'hf, 1'b0}) begin
      bad++; $display("FAIL async_reset ok=%0d got=%b want=%b", ok, got,
                      {7'h7f, 7'h7f, 4'hf, 1'b0});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (got !== {7'b1000000, 7'b1000000, 4'b1110, 1'b1}) begin
      bad++; $display("FAIL async_release got=%b want=%b", got,
                      {7'b1000000, 7'b1000000, 4'b1110, 1'b1});
    end
  endtask

  task automatic test_enable();
    do_load(16'h5678);
    enable = 1'b0;
    repeat (38) begin
      @(negedge clk);
      total++;
      if (got !== want || !hex_agree) begin
        bad++; $display("FAIL enable_off t=%0d got=%b want=%b", t, got, want);
      end
    end
    enable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      total++;
      if (got !== want || !hex_agree) begin
        bad++; $display("FAIL enable_on t=%0d got=%b want=%b", t, got, want);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    repeat (400) begin
      @(negedge clk);
      total++;
      if (got !== want || !hex_agree) begin
        bad++; $display("FAIL random t=%0d got=%b want=%b", t, got, want);
      end
      load = ($urandom_range(0, 5) == 0);
      for (int n = 0; n < 4; n++)
        v[n*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      digits_in = v;
      if ($urandom_range(0, 15) == 0) blink_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) lz_blank = ~lz_blank;
      enable = ($urandom_range(0, 9) != 0);
    end
    load = 1'b0; enable = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; load = 1'b0; digits_in = '0; blink_mask = '0; lz_blank = 1'b0; enable = 1'b1;
    test_reset();
    test_scan();
    test_lz();
    test_hex();
    test_blink();
    test_async_reset();
    test_enable();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
